line_sensor_conditioner: RTL and testbench

//   Front end between the three raw IR line sensors {front,left,right} and the line-follower
//   FSM that drives the motors. Synchronises the async pins, applies per-channel polarity,

---
 rtl/line_sensor_pkg.sv | 21 ++
 rtl/sensor_debounce.sv | 73 +++++++
 rtl/line_sensor_conditioner.sv | 125 ++++++++++++
 tb/tb_line_sensor_conditioner.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_sensor_pkg.sv
// Shared constants for the IR line-sensor front end: channel count and ordering,
// default timing parameters and a counter-width helper.
package line_sensor_pkg;

  localparam int NUM_CH = 3;

  // Bit positions inside every {f,l,r} vector
  localparam int CH_F = 2;
  localparam int CH_L = 1;
  localparam int CH_R = 0;

  localparam int DEF_PRESCALE   = 100;
  localparam int DEF_DEBOUNCE_N = 4;
  localparam int DEF_LOST_TICKS = 1000;

  // Bits needed to hold values 0..max_val, never less than one bit
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage : line_sensor_pkg

// File: rtl/sensor_debounce.sv
// One sensor channel: 2-flop synchroniser, polarity invert and a tick-driven
// debounce counter that flips the clean level after DEBOUNCE_N differing ticks.
// flip_o is high in the cycle before out_o takes its new value.
module sensor_debounce
  import line_sensor_pkg::*;
#(
  parameter int DEBOUNCE_N = DEF_DEBOUNCE_N
) (
  input  logic clk,
  input  logic reset_i,
  input  logic raw_i,
  input  logic invert_i,
  input  logic tick_i,
  output logic out_o,
  output logic flip_o
);

  localparam int DW = cnt_width(DEBOUNCE_N);

  logic          sync1_q;
  logic          sync2_q;
  logic          out_q;
  logic          out_d;
  logic [DW-1:0] dcnt_q;
  logic [DW-1:0] dcnt_d;
  logic          s;

  // Invert is applied after the synchroniser, so a polarity change is debounced too
  assign s = sync2_q ^ invert_i;

  // Two-stage synchroniser for the asynchronous sensor pin
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce decision: count consecutive differing ticks, flip on the last one
  always_comb begin
    dcnt_d = dcnt_q;
    out_d  = out_q;
    flip_o = 1'b0;
    if (tick_i) begin
      if (s == out_q) begin
        dcnt_d = '0;
      end else if (dcnt_q == DW'(DEBOUNCE_N - 1)) begin
        out_d  = s;
        dcnt_d = '0;
        flip_o = 1'b1;
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      dcnt_q <= '0;
      out_q  <= 1'b0;
    end else begin
      dcnt_q <= dcnt_d;
      out_q  <= out_d;
    end
  end

  assign out_o = out_q;

endmodule : sensor_debounce

// File: rtl/line_sensor_conditioner.sv
// Front end between the raw IR line sensors {f,l,r} and the line-follower FSM.
// Shared sample-tick prescaler, per-channel debounce, sticky valid flag and a
// one-cycle change pulse. Optional line-lost detection is built when the
// macro LINE_LOST_EN is defined; otherwise line_lost is tied low.
module line_sensor_conditioner
  import line_sensor_pkg::*;
#(
  parameter int PRESCALE   = DEF_PRESCALE,
  parameter int DEBOUNCE_N = DEF_DEBOUNCE_N,
  parameter int LOST_TICKS = DEF_LOST_TICKS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] raw_sensor,
  input  logic [NUM_CH-1:0] cfg_invert,
  output logic [NUM_CH-1:0] sensor_out,
  output logic              sensor_vld,
  output logic              sensor_chg,
  output logic              line_lost
);

  localparam int PW = cnt_width(PRESCALE - 1);
  localparam int VW = cnt_width(DEBOUNCE_N);

  if (PRESCALE < 1 || DEBOUNCE_N < 1 || LOST_TICKS < 1) begin : g_param_check
    $error("line_sensor_conditioner: PRESCALE, DEBOUNCE_N and LOST_TICKS must be >= 1");
  end

  logic [PW-1:0]     pre_cnt_q;
  logic              tick;
  logic [VW-1:0]     vcnt_q;
  logic              vld_q;
  logic              chg_q;
  logic [NUM_CH-1:0] flip;
  logic [NUM_CH-1:0] out_d;

  assign tick = (pre_cnt_q == PW'(PRESCALE - 1));

  // Sample-tick prescaler: counts 0..PRESCALE-1 and wraps on the tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt_q <= '0;
    end else if (tick) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_q + PW'(1);
    end
  end

  // One debouncer per channel; index order follows CH_F/CH_L/CH_R
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    sensor_debounce #(
      .DEBOUNCE_N(DEBOUNCE_N)
    ) u_deb (
      .clk     (clk),
      .reset_i (reset),
      .raw_i   (raw_sensor[gi]),
      .invert_i(cfg_invert[gi]),
      .tick_i  (tick),
      .out_o   (sensor_out[gi]),
      .flip_o  (flip[gi])
    );
  end

  // Level sensor_out will hold after this edge
  assign out_d = sensor_out ^ flip;

  // Valid becomes sticky once a full debounce window of ticks has elapsed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vcnt_q <= '0;
      vld_q  <= 1'b0;
    end else if (tick) begin
      if (vcnt_q != VW'(DEBOUNCE_N)) vcnt_q <= vcnt_q + VW'(1);
      if (vcnt_q == VW'(DEBOUNCE_N - 1)) vld_q <= 1'b1;
    end
  end

  // Change pulse lands on the same edge as the new sensor_out, one per tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) chg_q <= 1'b0;
    else       chg_q <= |flip;
  end

  assign sensor_vld = vld_q;
  assign sensor_chg = chg_q;

`ifdef LINE_LOST_EN
  localparam int LW = cnt_width(LOST_TICKS);

  logic [LW-1:0] lcnt_q;
  logic [LW-1:0] lcnt_d;
  logic          lost_q;
  logic          lost_d;

  // Count all-dark ticks once valid; any line seen clears count and flag
  always_comb begin
    lcnt_d = lcnt_q;
    lost_d = lost_q;
    if (|out_d) begin
      lcnt_d = '0;
      lost_d = 1'b0;
    end else if (tick && vld_q && (sensor_out == '0)) begin
      if (lcnt_q != LW'(LOST_TICKS)) lcnt_d = lcnt_q + LW'(1);
      if (lcnt_q >= LW'(LOST_TICKS - 1)) lost_d = 1'b1;
    end
  end

  // Line-lost state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lcnt_q <= '0;
      lost_q <= 1'b0;
    end else begin
      lcnt_q <= lcnt_d;
      lost_q <= lost_d;
    end
  end

  assign line_lost = lost_q;
`else
  assign line_lost = 1'b0;
`endif

endmodule : line_sensor_conditioner

// File: tb/tb_line_sensor_conditioner.sv
// Self-checking bench for line_sensor_conditioner. A fast instance (PRESCALE=1)
// is compared every cycle against a streak-based reference model; a slow
// instance (PRESCALE=100) checks reset-discarded debounce progress.
// Line-lost checks follow LINE_LOST_EN.
module tb_line_sensor_conditioner;

  localparam int PS      = 1;
  localparam int DEB     = 4;
  localparam int LT      = 10;
  localparam int PS_SLOW = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] raw_sensor;
  logic [2:0] cfg_invert;
  logic [2:0] sensor_out;
  logic       sensor_vld;
  logic       sensor_chg;
  logic       line_lost;

  logic       reset_slow;
  logic [2:0] raw_slow;
  logic [2:0] inv_slow;
  logic [2:0] out_slow;
  logic       vld_slow;
  logic       chg_slow;
  logic       lost_slow;

  always #5 clk = ~clk;

  line_sensor_conditioner #(
    .PRESCALE(PS), .DEBOUNCE_N(DEB), .LOST_TICKS(LT)
  ) u_dut (
    .clk(clk), .reset(reset), .raw_sensor(raw_sensor), .cfg_invert(cfg_invert),
    .sensor_out(sensor_out), .sensor_vld(sensor_vld), .sensor_chg(sensor_chg),
    .line_lost(line_lost)
  );

  line_sensor_conditioner #(
    .PRESCALE(PS_SLOW), .DEBOUNCE_N(DEB), .LOST_TICKS(LT)
  ) u_dut_slow (
    .clk(clk), .reset(reset_slow), .raw_sensor(raw_slow), .cfg_invert(inv_slow),
    .sensor_out(out_slow), .sensor_vld(vld_slow), .sensor_chg(chg_slow),
    .line_lost(lost_slow)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pins reach the debouncer two edges late; a channel flips
  // after DEB consecutive ticks where its sampled value differs from the output.
  logic [2:0] hist[$];
  logic [2:0] m_out;
  int         streak[3];
  int         m_ticks;
  logic       m_vld;
  logic       m_chg;
  int         m_lcnt;
  logic       m_lost;

  task automatic model_clear();
    hist.delete();
    hist.push_back(3'b000);
    hist.push_back(3'b000);
    m_out   = 3'b000;
    for (int c = 0; c < 3; c++) streak[c] = 0;
    m_ticks = 0;
    m_vld   = 1'b0;
    m_chg   = 1'b0;
    m_lcnt  = 0;
    m_lost  = 1'b0;
  endtask

  // Advance the model by one clock edge using the pre-edge inputs
  task automatic model_edge();
    logic [2:0] s;
    logic [2:0] nxt;
    if (reset) begin
      model_clear();
    end else begin
      s = hist[0] ^ cfg_invert;
      hist.push_back(raw_sensor);
      void'(hist.pop_front());
      nxt = m_out;
      for (int c = 0; c < 3; c++) begin
        if (s[c] != m_out[c]) streak[c]++;
        else                  streak[c] = 0;
        if (streak[c] == DEB) begin
          nxt[c]    = s[c];
          streak[c] = 0;
        end
      end
      m_chg = (nxt != m_out);
`ifdef LINE_LOST_EN
      if (nxt != 3'b000) begin
        m_lcnt = 0;
        m_lost = 1'b0;
      end else if (m_vld && m_out == 3'b000) begin
        if (m_lcnt < LT) m_lcnt++;
        if (m_lcnt >= LT) m_lost = 1'b1;
      end
`endif
      if (m_ticks < DEB) m_ticks++;
      m_vld = (m_ticks >= DEB);
      m_out = nxt;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_main();
    chk("out", 32'(sensor_out), 32'(m_out));
    chk("vld", 32'(sensor_vld), 32'(m_vld));
    chk("chg", 32'(sensor_chg), 32'(m_chg));
    chk("lost", 32'(line_lost), 32'(m_lost));
    $display("t=%0t raw=%b inv=%b rst=%b out=%b vld=%b chg=%b lost=%b", $time,
             raw_sensor, cfg_invert, reset, sensor_out, sensor_vld, sensor_chg, line_lost);
  endtask

  // One clock edge: update model at the edge, sample DUT 1 time unit later
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_main();
  endtask

  initial begin
    int n;
    int chg_seen;
    int hold;
    logic [31:0] lost_exp;

    reset      = 1'b1;
    raw_sensor = 3'b000;
    cfg_invert = 3'b000;
    reset_slow = 1'b1;
    raw_slow   = 3'b000;
    inv_slow   = 3'b000;
    model_clear();
    #1;
    check_main();
    repeat (3) step();

    // Release: sensor_vld must rise on the 4th tick
    reset = 1'b0;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (sensor_vld) begin n = i; break; end
    end
    chk("vld_latency", 32'(n), 32'(DEB));
    repeat (3) step();

    // Glitch of 3 cycles on F: no output change, no pulse
    raw_sensor = 3'b100;
    chg_seen = 0;
    for (int i = 0; i < 3; i++) begin step(); if (sensor_chg) chg_seen++; end
    raw_sensor = 3'b000;
    for (int i = 0; i < 12; i++) begin step(); if (sensor_chg) chg_seen++; end
    chk("glitch_out", 32'(sensor_out), 32'h0);
    chk("glitch_chg", 32'(chg_seen), 32'h0);

    // F held: output appears at edge k+1+DEB, i.e. count 2+DEB from edge k
    raw_sensor = 3'b100;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (sensor_out == 3'b100) begin n = i; break; end
    end
    chk("f_latency", 32'(n), 32'(2 + DEB));
    chk("f_chg_on", 32'(sensor_chg), 32'h1);
    step();
    chk("f_chg_off", 32'(sensor_chg), 32'h0);
    raw_sensor = 3'b000;
    repeat (10) step();

    // Invert all with pins low: single pulse, out = 111
    cfg_invert = 3'b111;
    chg_seen = 0;
    for (int i = 0; i < 15; i++) begin step(); if (sensor_chg) chg_seen++; end
    chk("inv_out", 32'(sensor_out), 32'h7);
    chk("inv_chg_count", 32'(chg_seen), 32'h1);
    cfg_invert = 3'b000;
    repeat (10) step();

    // Line lost after LT dark ticks; clears on the edge L appears
`ifdef LINE_LOST_EN
    lost_exp = 32'h1;
`else
    lost_exp = 32'h0;
`endif
    repeat (LT + 2) step();
    chk("lost_set", 32'(line_lost), lost_exp);
    raw_sensor = 3'b010;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (sensor_out == 3'b010) begin n = i; break; end
    end
    chk("l_latency", 32'(n), 32'(2 + DEB));
    chk("lost_clear", 32'(line_lost), 32'h0);
    step();

    // Asynchronous reset mid-cycle clears outputs immediately
    #3;
    reset = 1'b1;
    model_clear();
    #1;
    chk("arst_out", 32'(sensor_out), 32'h0);
    chk("arst_vld", 32'(sensor_vld), 32'h0);
    chk("arst_chg", 32'(sensor_chg), 32'h0);
    chk("arst_lost", 32'(line_lost), 32'h0);
    repeat (2) step();
    reset = 1'b0;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (sensor_vld) begin n = i; break; end
    end
    chk("vld_after_rst", 32'(n), 32'(DEB));
    repeat (4) step();

    // Randomised run against the model, with occasional async resets
    hold = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        raw_sensor = 3'($urandom_range(0, 7));
        hold = $urandom_range(1, 7);
        if ($urandom_range(0, 9) == 0) cfg_invert = 3'($urandom_range(0, 7));
      end
      hold--;
      if (reset) begin
        reset = 1'b0;
      end else if ($urandom_range(0, 199) == 0) begin
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        check_main();
      end
      step();
    end

    // Slow instance: 3 ticks of progress, reset, then a full window again
    @(posedge clk); #1;
    reset_slow = 1'b0;
    raw_slow   = 3'b100;
    repeat (3 * PS_SLOW) @(posedge clk);
    #1;
    chk("slow_pre_rst", 32'(out_slow), 32'h0);
    #2;
    reset_slow = 1'b1;
    #1;
    chk("slow_rst_out", 32'(out_slow), 32'h0);
    @(posedge clk); #1;
    reset_slow = 1'b0;
    n = 0;
    for (int i = 1; i <= 1000; i++) begin
      @(posedge clk); #1;
      if (out_slow == 3'b100) begin n = i; break; end
    end
    chk("slow_latency", 32'(n), 32'(DEB * PS_SLOW));
    chk("slow_chg", 32'(chg_slow), 32'h1);
    chk("slow_vld", 32'(vld_slow), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_line_sensor_conditioner
